// File: rtl/period_meter.sv
// Measures period and high time, in i_Clock cycles, of an asynchronous periodic input.
// Define PERIOD_METER_DUTY_EN to build the high-time counter; otherwise o_HighTime reads 0.
module period_meter #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Enable,
    input  logic                 i_Signal,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic [CNT_WIDTH-1:0] o_Period,
    output logic [CNT_WIDTH-1:0] o_HighTime,
    output logic                 o_Overflow
);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    typedef enum logic {StIdle, StMeasure} state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   synced, rise;
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   per_cnt_q, per_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   cand, load;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   res_per_q, res_per_d;
    logic                   res_ovf_q, res_ovf_d;

    // sync_q[0] is the first (metastability-catching) stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_Signal};
        synced = sync_q[SYNC_STAGES-1];
        prev_d = synced;
        rise   = synced && !prev_q;
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        ovf_d     = ovf_q;
        cand      = 1'b0;
        case (state_q)
            StIdle: begin
                per_cnt_d = '0;
                ovf_d     = 1'b0;
                if (rise) begin
                    state_d   = StMeasure;
                    per_cnt_d = CntOne;
                end
            end
            StMeasure: begin
                if (rise) begin
                    cand      = 1'b1;
                    per_cnt_d = CntOne;
                    ovf_d     = 1'b0;
                end else if (per_cnt_q == CntMax) begin
                    ovf_d = 1'b1;
                end else begin
                    per_cnt_d = per_cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
        // Disable wins over everything, including a coincident rise.
        if (!i_Enable) begin
            state_d   = StIdle;
            per_cnt_d = '0;
            ovf_d     = 1'b0;
            cand      = 1'b0;
        end
    end

    always_comb begin
        load      = cand && (!valid_q || i_Ready);
        valid_d   = valid_q;
        res_per_d = res_per_q;
        res_ovf_d = res_ovf_q;
        if (load) begin
            valid_d   = 1'b1;
            res_per_d = per_cnt_q;
            res_ovf_d = ovf_q;
        end else if (valid_q && i_Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= StIdle;
            per_cnt_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            res_per_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            res_per_q <= res_per_d;
            res_ovf_q <= res_ovf_d;
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_WIDTH-1:0] res_high_q, res_high_d;

    always_comb begin
        hi_cnt_d   = hi_cnt_q;
        res_high_d = res_high_q;
        if (!i_Enable) begin
            hi_cnt_d = '0;
        end else if (rise) begin
            hi_cnt_d = CntOne;
        end else if (state_q == StIdle) begin
            hi_cnt_d = '0;
        end else if (synced && (hi_cnt_q != CntMax)) begin
            hi_cnt_d = hi_cnt_q + CntOne;
        end
        if (load) begin
            res_high_d = hi_cnt_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            hi_cnt_q   <= '0;
            res_high_q <= '0;
        end else begin
            hi_cnt_q   <= hi_cnt_d;
            res_high_q <= res_high_d;
        end
    end

    assign o_HighTime = res_high_q;
`else
    assign o_HighTime = '0;
`endif

    assign o_Valid    = valid_q;
    assign o_Period   = res_per_q;
    assign o_Overflow = res_ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter: a 16-bit and an 8-bit instance share one stimulus and are
// compared every cycle against a timestamp-based reference model.
module tb_period_meter;

`ifdef PERIOD_METER_DUTY_EN
    localparam bit DutyEn = 1'b1;
`else
    localparam bit DutyEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, sig, rdy;
    logic        v_a, v_b, o_a, o_b;
    logic [15:0] p_a, h_a;
    logic [7:0]  p_b, h_b;

    always #5 clk = ~clk;

    period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut_a (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Signal(sig), .o_Valid(v_a),
        .i_Ready(rdy), .o_Period(p_a), .o_HighTime(h_a), .o_Overflow(o_a)
    );

    period_meter #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Signal(sig), .o_Valid(v_b),
        .i_Ready(rdy), .o_Period(p_b), .o_HighTime(h_b), .o_Overflow(o_b)
    );

    int              n_checks = 0;
    int              n_errors = 0;
    bit              hist[$];         // i_Signal as seen by the synchronizer at each clock edge
    int              last_rise = -1;  // edge index of the last rise pulse, -1 when idle
    longint          hi_acc = 0;
    longint unsigned max_v[2] = '{64'd65535, 64'd255};
    bit              ev[2];
    longint unsigned ep[2], eh[2];
    bit              eo[2];
    int              phase = 0;
    bit              rdy_rand = 1'b0;
    int              const_valid = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Rise pulse at edge m reflects the input sampled at edges m-2 (high) and m-3 (low).
    function automatic void model_edge();
        int     m;
        bit     syn, prv, rise, cand;
        longint cp, ch;
        if (!rst_n) begin
            hist.push_back(1'b0);
            return;
        end
        hist.push_back(sig);
        m    = hist.size() - 1;
        syn  = (m >= 2) ? hist[m-2] : 1'b0;
        prv  = (m >= 3) ? hist[m-3] : 1'b0;
        rise = syn && !prv;
        cand = 1'b0;
        cp   = 0;
        ch   = 0;
        if (!en) begin
            last_rise = -1;
            hi_acc    = 0;
        end else if (rise) begin
            if (last_rise >= 0) begin
                cand = 1'b1;
                cp   = longint'(m - last_rise);
                ch   = hi_acc;
            end
            last_rise = m;
            hi_acc    = 1;
        end else if (last_rise >= 0) begin
            hi_acc += longint'(syn);
        end
        for (int i = 0; i < 2; i++) begin
            if (cand && (!ev[i] || rdy)) begin
                ev[i] = 1'b1;
                ep[i] = (longint'(max_v[i]) < cp) ? max_v[i] : longint'(cp);
                eh[i] = !DutyEn ? 0 : ((longint'(max_v[i]) < ch) ? max_v[i] : longint'(ch));
                eo[i] = longint'(max_v[i]) < cp;
            end else if (ev[i] && rdy) begin
                ev[i] = 1'b0;
            end
        end
    endfunction

    function automatic void model_async_reset();
        for (int k = 0; k < 3; k++) begin
            if (hist.size() > k) hist[hist.size()-1-k] = 1'b0;
        end
        last_rise = -1;
        hi_acc    = 0;
        for (int i = 0; i < 2; i++) begin
            ev[i] = 1'b0;
            ep[i] = 0;
            eh[i] = 0;
            eo[i] = 1'b0;
        end
    endfunction

    task automatic compare_all();
        check_eq("w16 valid",    32'(v_a), 32'(ev[0]));
        check_eq("w16 period",   32'(p_a), 32'(ep[0]));
        check_eq("w16 hightime", 32'(h_a), 32'(eh[0]));
        check_eq("w16 overflow", 32'(o_a), 32'(eo[0]));
        check_eq("w8 valid",     32'(v_b), 32'(ev[1]));
        check_eq("w8 period",    32'(p_b), 32'(ep[1]));
        check_eq("w8 hightime",  32'(h_b), 32'(eh[1]));
        check_eq("w8 overflow",  32'(o_b), 32'(eo[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_async_reset();
        compare_all();
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    task automatic wave(input int per, input int hi, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            phase = phase % per;
            sig   = (phase < hi);
            if (rdy_rand) rdy = ($urandom_range(0, 3) != 0);
            tick();
            phase++;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        sig   = 1'b0;
        rdy   = 1'b1;
        #2;
        do_reset(3);
        en = 1'b1;

        // 256-cycle square wave, always ready
        wave(256, 128, 1100);
        check_eq("sq256 period", 32'(p_a), 32'd256);
        check_eq("sq256 high",   32'(h_a), DutyEn ? 32'd128 : 32'd0);
        check_eq("sq256 ovf",    32'(o_a), 32'd0);

        // Back-pressure: held result, later candidates dropped
        rdy = 1'b0;
        wave(256, 128, 1000);
        check_eq("held period", 32'(p_a), 32'd256);
        rdy = 1'b1;
        wave(256, 128, 600);

        // Overflow on the 8-bit instance, then recovery
        wave(300, 100, 900);
        check_eq("w8 sat period", 32'(p_b), 32'd255);
        check_eq("w8 sat ovf",    32'(o_b), 32'd1);
        check_eq("w8 sat high",   32'(h_b), DutyEn ? 32'd100 : 32'd0);
        check_eq("w16 p300",      32'(p_a), 32'd300);
        wave(200, 100, 700);
        check_eq("w8 p200",     32'(p_b), 32'd200);
        check_eq("w8 p200 ovf", 32'(o_b), 32'd0);

        // Random waveforms with random back-pressure
        rdy_rand = 1'b1;
        for (int s = 0; s < 6; s++) begin
            int per, hi;
            per = int'($urandom_range(2, 300));
            hi  = int'($urandom_range(1, per - 1));
            wave(per, hi, per * int'($urandom_range(2, 5)));
        end
        rdy_rand = 1'b0;
        rdy      = 1'b1;

        // Enable dropped mid-period, then a 64-cycle wave
        wave(256, 128, 100);
        en = 1'b0;
        wave(256, 128, 50);
        en = 1'b1;
        wave(64, 32, 320);
        check_eq("reenable p64", 32'(p_a), 32'd64);

        // Async reset while a result is pending
        rdy = 1'b0;
        for (int g = 0; g < 2000 && !ev[0]; g++) wave(256, 128, 1);
        check_eq("pre-reset valid", 32'(v_a), 32'd1);
        wave(256, 128, 30);
        do_reset(3);
        rdy = 1'b1;
        wave(256, 128, 800);
        check_eq("post-reset period", 32'(p_a), 32'd256);

        // Constant input: never a result
        do_reset(3);
        sig = 1'b0;
        repeat (1000) begin
            tick();
            if (v_a || v_b) const_valid++;
        end
        sig = 1'b1;
        repeat (70000) begin
            tick();
            if (v_a || v_b) const_valid++;
        end
        check_eq("const no valid", 32'(const_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
